// File: rtl/pattern_tx_pkg.sv
// Shared constants for the serial pattern transmitter: FSM state codes and
// repetition counter width.
package pattern_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int REP_W = 4;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register; serial data leaves from the MSB.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sr_q <= '0;
    else if (load_i)  sr_q <= din_i;
    else if (shift_i) sr_q <= {sr_q[WIDTH-2:0], 1'b0};
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: loads a pattern + repeat count via valid/ready,
// then shifts it out MSB-first for repeat_cnt+1 repetitions with optional gaps.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   GAP_LEN  = 0,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             sr_load, sr_shift, sr_msb;
  logic [WIDTH-1:0] sr_din;

  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .din_i   (sr_din),
    .msb_o   (sr_msb)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    rep_d    = rep_q;
    reload_d = reload_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = reload_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          state_d  = ST_SHIFT;
          bit_d    = '0;
          rep_d    = repeat_cnt;
          reload_d = pattern;
          sr_load  = 1'b1;
          sr_din   = pattern;
        end
      end
      ST_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (rep_q == '0) begin
            state_d = ST_DONE;
          end else begin
            rep_d = rep_q - 1'b1;
            // Without a gap the reload lands on the same edge, so the next
            // repetition's MSB follows the last bit with no bubble.
            if (GAP_LEN > 0) begin
              state_d = ST_GAP;
              gap_d   = '0;
            end else begin
              sr_load = 1'b1;
            end
          end
        end else begin
          bit_d    = bit_q + 1'b1;
          sr_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          sr_load = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      bit_d    = '0;
      gap_d    = '0;
      rep_d    = '0;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      gap_q    <= '0;
      rep_q    <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      rep_q    <= rep_d;
      reload_q <= reload_d;
    end
  end

  // Outputs decode flops only; no input reaches an output combinationally.
  assign dout       = (state_q == ST_SHIFT) ? sr_msb : IDLE_BIT;
  assign dout_valid = (state_q == ST_SHIFT);
  assign busy       = (state_q != ST_IDLE);
  assign load_ready = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench: two transmitters (no gap / 3-cycle gap) share stimulus;
// each has an expected per-cycle output stream built from the job description.
module tb_pattern_tx;

  localparam int W = 8;
  localparam int GAPS [2] = '{0, 3};

  typedef struct packed {
    logic dout;
    logic vld;
    logic done;
    logic busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] pattern = '0;
  logic [3:0]   repeat_cnt = '0;
  logic [1:0]   dout_w, vld_w, done_w, busy_w, rdy_w;

  exp_t q [2][$];
  int   checks = 0;
  int   passes = 0;

  pattern_tx #(.WIDTH(W), .GAP_LEN(0), .IDLE_BIT(1'b1)) u_nogap (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_w[0]),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .dout(dout_w[0]), .dout_valid(vld_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  pattern_tx #(.WIDTH(W), .GAP_LEN(3), .IDLE_BIT(1'b1)) u_gap (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(rdy_w[1]),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .abort(abort),
    .dout(dout_w[1]), .dout_valid(vld_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [4:0] act, logic [4:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got {dout,vld,done,busy,rdy}=%b want %b", name, act, req);
  endfunction

  // Expected stream per cycle, starting the cycle after the handshake edge.
  function automatic void push_job(int k, logic [W-1:0] p, int r);
    exp_t e;
    for (int rep = 0; rep <= r; rep++) begin
      for (int i = 0; i < W; i++) begin
        e = '{dout: p[W-1-i], vld: 1'b1, done: 1'b0, busy: 1'b1};
        q[k].push_back(e);
      end
      if (rep < r)
        for (int g = 0; g < GAPS[k]; g++) begin
          e = '{dout: 1'b1, vld: 1'b0, done: 1'b0, busy: 1'b1};
          q[k].push_back(e);
        end
    end
    e = '{dout: 1'b1, vld: 1'b0, done: 1'b1, busy: 1'b1};
    q[k].push_back(e);
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      if (q[k].size() > 0) e = q[k].pop_front();
      else e = '{dout: 1'b1, vld: 1'b0, done: 1'b0, busy: 1'b0};
      chk($sformatf("dut%0d_t%0t", k, $time),
          {dout_w[k], vld_w[k], done_w[k], busy_w[k], rdy_w[k]},
          {e.dout, e.vld, e.done, e.busy, ~e.busy});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 1000) begin
      cyc();
      n++;
    end
    if (n >= 1000) begin
      checks++;
      $display("FAIL idle_timeout: queues %0d/%0d still pending, want 0", q[0].size(), q[1].size());
      q[0].delete();
      q[1].delete();
    end
  endtask

  task automatic do_load(logic [W-1:0] p, int r, logic ab);
    wait_idle();
    load_valid = 1'b1;
    pattern    = p;
    repeat_cnt = 4'(r);
    abort      = ab;
    @(posedge clk);
    for (int k = 0; k < 2; k++) push_job(k, p, r);
    #1;
    load_valid = 1'b0;
    abort      = 1'b0;
    pattern    = W'($urandom);
    repeat_cnt = 4'($urandom);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk);
    q[0].delete();
    q[1].delete();
    #1;
    abort = 1'b0;
  endtask

  // Loads while both units are busy must be dropped.
  task automatic spurious(int n);
    for (int i = 0; i < n; i++) begin
      if (q[0].size() == 0 || q[1].size() == 0) break;
      load_valid = 1'($urandom);
      pattern    = W'($urandom);
      repeat_cnt = 4'($urandom);
      cyc();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_nogap", {dout_w[0], vld_w[0], done_w[0], busy_w[0], rdy_w[0]}, 5'b10001);
    chk("reset_gap",   {dout_w[1], vld_w[1], done_w[1], busy_w[1], rdy_w[1]}, 5'b10001);
    rst_n = 1'b1;
    cyc();

    do_load(8'h55, 0, 1'b0);
    do_load(8'hA5, 2, 1'b0);
    do_load(8'hF0, 1, 1'b0);

    // Ignored load at bit 0, abort during bit 4, reload right after.
    do_load(8'h3C, 1, 1'b0);
    load_valid = 1'b1;
    pattern    = 8'hFF;
    cyc();
    load_valid = 1'b0;
    repeat (3) cyc();
    do_abort();
    do_load(8'h96, 0, 1'b0);

    // abort alongside a load in IDLE does not block it
    do_load(8'h81, 1, 1'b1);

    // asynchronous reset mid-shift
    do_load(8'hA5, 2, 1'b0);
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    #1;
    chk("async_rst_nogap", {dout_w[0], vld_w[0], done_w[0], busy_w[0], rdy_w[0]}, 5'b10001);
    chk("async_rst_gap",   {dout_w[1], vld_w[1], done_w[1], busy_w[1], rdy_w[1]}, 5'b10001);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    for (int it = 0; it < 40; it++) begin
      do_load(W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 7) == 0));
      case ($urandom_range(0, 3))
        0: spurious($urandom_range(1, 12));
        1: begin
          repeat ($urandom_range(0, 25)) cyc();
          do_abort();
        end
        default: ;
      endcase
      wait_idle();
      repeat ($urandom_range(0, 2)) cyc();
    end

    wait_idle();
    repeat (3) cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
